// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//   Multi-digit BCD stopwatch with optional lap (split) freeze and a
//   multiplexed, active-low 7-segment display driver for a common-anode board.
//
//   Optional feature macro: STOPWATCH_LAP_EN
//     defined   -> LAP state, display latch and the lap button are present.
//     undefined -> lap is ignored; STOPPED can only be cleared by reset.
//
//   Parameters
//     TICK_DIV    clk cycles per 1/100 s tick (>= 2)
//     REFRESH_DIV clk cycles each digit stays enabled while scanning (>= 1)
//     NUM_DIGITS  number of BCD digits, 4..8
//
//   Ports
//     clk       in   system clock, rising edge
//     reset     in   synchronous, active-high; clears all state
//     start     in   debounced level; rising edge starts / resumes
//     stop      in   debounced level; rising edge stops / releases lap freeze
//     lap       in   debounced level; rising edge toggles lap freeze
//     segment   out  [6:0] active-low cathodes {g,f,e,d,c,b,a}
//     an        out  [NUM_DIGITS-1:0] active-low digit enables, bit 0 rightmost
//     dp        out  active-low decimal point
//     running   out  high while counting (RUN or LAP)
//     overflow  out  sticky count-wrap flag
//     dbg_state out  [1:0] current FSM state (IDLE=0, RUN=1, STOPPED=2, LAP=3)
module lap_stopwatch #(
  parameter int TICK_DIV    = 1_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  lap,
  output logic [6:0]            segment,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  running,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STOPPED = 2'd2,
    S_LAP     = 2'd3
  } state_t;

  // Seconds-tens and minutes-tens roll over at 5; every other digit at 9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  state_t                       r_state;
  logic                         r_running;
  logic                         r_overflow;
  logic [PW-1:0]                r_presc;
  logic [NUM_DIGITS-1:0][3:0]   r_count;
  logic [2:0]                   r_sync;   // {start, stop, lap}
  logic [2:0]                   r_prev;
  logic [SW-1:0]                r_scan_cnt;
  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0]        r_an;
  logic [6:0]                   r_seg;
  logic                         r_dp;

  logic [2:0]                   w_edge;
  logic                         w_start_e;
  logic                         w_stop_e;
  logic                         w_lap_e;
  logic                         w_tick;
  logic                         w_wrap;
  logic [NUM_DIGITS-1:0][3:0]   w_inc;
  logic [NUM_DIGITS-1:0][3:0]   w_disp;

  assign w_edge    = r_sync & ~r_prev;
  assign w_start_e = w_edge[2];
  assign w_stop_e  = w_edge[1];
  assign w_tick    = (r_state == S_RUN || r_state == S_LAP) &&
                     (r_presc == PW'(TICK_DIV - 1));

`ifdef STOPWATCH_LAP_EN
  logic [NUM_DIGITS-1:0][3:0]   r_latch;
  assign w_lap_e = w_edge[0];
  assign w_disp  = (r_state == S_LAP) ? r_latch : r_count;
`else
  logic w_lap_unused;
  assign w_lap_unused = w_edge[0];
  assign w_lap_e      = 1'b0;
  assign w_disp       = r_count;
`endif

  // Ripple carry: a digit advances only if every lower digit is wrapping.
  always_comb begin : count_inc
    logic v_carry;
    w_inc   = r_count;
    v_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_carry) begin
        if (r_count[i] == digit_max(i)) begin
          w_inc[i] = 4'd0;
        end else begin
          w_inc[i] = r_count[i] + 4'd1;
          v_carry  = 1'b0;
        end
      end
    end
    w_wrap = v_carry;
  end

  // Control FSM, prescaler and digit chain. Counting happens first; a
  // transition taken on the same edge overrides the fields it touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      r_presc    <= '0;
      r_count    <= '0;
      r_sync     <= '0;
      r_prev     <= '0;
`ifdef STOPWATCH_LAP_EN
      r_latch    <= '0;
`endif
    end else begin
      r_sync <= {start, stop, lap};
      r_prev <= r_sync;

      if (r_state == S_RUN || r_state == S_LAP) begin
        if (w_tick) begin
          r_presc <= '0;
          r_count <= w_inc;
          if (w_wrap) r_overflow <= 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end

      // Legal edges are tested in priority order stop > lap > start.
      case (r_state)
        S_IDLE: begin
          if (w_start_e) begin
            r_state    <= S_RUN;
            r_running  <= 1'b1;
            r_count    <= '0;
            r_presc    <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_stop_e) begin
            r_state   <= S_STOPPED;
            r_running <= 1'b0;
          end else if (w_lap_e) begin
            r_state <= S_LAP;
`ifdef STOPWATCH_LAP_EN
            r_latch <= r_count;
`endif
          end
        end
        S_STOPPED: begin
          if (w_lap_e) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (w_start_e) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_LAP: begin
          if (w_stop_e) begin
            r_state   <= S_STOPPED;
            r_running <= 1'b0;
          end else if (w_lap_e) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Free-running display scan; outputs are registered from the current index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_an       <= ~NUM_DIGITS'(1);
      r_seg      <= 7'b1000000;
      r_dp       <= 1'b1;
    end else begin
      if (r_scan_cnt == SW'(REFRESH_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= seg7(w_disp[r_idx]);
      // Separators: seconds.hundredths, and minutes:seconds when present.
      r_dp  <= ~((int'(r_idx) == 2) || ((NUM_DIGITS >= 5) && (int'(r_idx) == 4)));
    end
  end

  assign segment   = r_seg;
  assign an        = r_an;
  assign dp        = r_dp;
  assign running   = r_running;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
